// File: rtl/pc_stack_counter_pkg.sv
// Shared types and width helpers for the program counter / return-address stack.
// Optional relative-branch support is enabled with `define PC_REL_BRANCH_EN.
package pc_pkg;

    localparam int unsigned ADDR_W_DEF      = 12;
    localparam int unsigned STACK_DEPTH_DEF = 4;
    localparam int unsigned STACK_DEPTH_MAX = 16;

    // Stack pointer counts 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int unsigned sp_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned SP_W_DEF = sp_width(STACK_DEPTH_DEF);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_LOAD,
        OP_REL,
        OP_CALL,
        OP_RET
    } pc_op_t;

endpackage

// File: rtl/pc_stack_counter_if.sv
// Decoder-to-program-counter bus: control strobes in, address and stack status out.
// Carries rel_branch/rel_offset only when PC_REL_BRANCH_EN is defined.
interface pc_stack_counter_if #(
    parameter int unsigned ADDR_W = pc_pkg::ADDR_W_DEF,
    parameter int unsigned SP_W   = pc_pkg::SP_W_DEF
);

    logic              enable;
    logic              load;
    logic              call;
    logic              ret;
    logic              clear_err;
    logic [ADDR_W-1:0] load_value;
`ifdef PC_REL_BRANCH_EN
    logic              rel_branch;
    logic [ADDR_W-1:0] rel_offset;
`endif
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   sp;
    logic              stack_full;
    logic              stack_empty;
    logic              overflow_err;
    logic              underflow_err;

    modport master (
`ifdef PC_REL_BRANCH_EN
        output rel_branch, rel_offset,
`endif
        output enable, load, call, ret, clear_err, load_value,
        input  pc, sp, stack_full, stack_empty, overflow_err, underflow_err
    );

    modport slave (
`ifdef PC_REL_BRANCH_EN
        input  rel_branch, rel_offset,
`endif
        input  enable, load, call, ret, clear_err, load_value,
        output pc, sp, stack_full, stack_empty, overflow_err, underflow_err
    );

endinterface

// File: rtl/pc_stack_counter_lifo.sv
// Return-address LIFO: registered entries and count, combinational top/full/empty.
module ret_addr_lifo #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] top_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              push_ok_c;
    logic              pop_ok_c;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_ok_c = push_i & ~full_o;
    assign pop_ok_c  = pop_i & ~empty_o & ~push_i;
    assign count_o   = count_q;

    always_comb begin
        count_d = count_q;
        if (push_ok_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Only the entry just below the pointer is ever selected; empty reads as zero.
    always_comb begin
        top_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (count_q == CNT_W'(i + 1)) begin
                top_o = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (push_ok_c && (count_q == CNT_W'(i))) begin
                    mem_q[i] <= data_i;
                end
            end
        end
    end

endmodule

// File: rtl/pc_stack_counter.sv
// Program counter with call/return stack, sticky stack-error flags and full/empty status.
// Define PC_REL_BRANCH_EN to add pc-relative branching below load in priority.
module pc_stack_counter
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W      = ADDR_W_DEF,
    parameter int unsigned       STACK_DEPTH = STACK_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input logic               clk,
    input logic               reset,
    pc_stack_counter_if.slave bus
);

    localparam int unsigned SP_W = sp_width(STACK_DEPTH);

    pc_op_t            op_c;
    logic              push_c;
    logic              pop_c;
    logic [ADDR_W-1:0] ret_addr_c;
    logic [ADDR_W-1:0] lifo_top;
    logic [SP_W-1:0]   lifo_count;
    logic              lifo_full;
    logic              lifo_empty;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;

    // One action per cycle: ret > call > load > rel_branch > enable > hold.
    always_comb begin
        op_c = OP_HOLD;
        if (bus.ret) begin
            op_c = OP_RET;
        end else if (bus.call) begin
            op_c = OP_CALL;
        end else if (bus.load) begin
            op_c = OP_LOAD;
`ifdef PC_REL_BRANCH_EN
        end else if (bus.rel_branch) begin
            op_c = OP_REL;
`endif
        end else if (bus.enable) begin
            op_c = OP_INC;
        end
    end

    assign push_c     = (op_c == OP_CALL) & ~lifo_full;
    assign pop_c      = (op_c == OP_RET) & ~lifo_empty;
    assign ret_addr_c = pc_q + ADDR_W'(1);

    // Clear is applied first so a coincident new error leaves the flag set.
    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q & ~bus.clear_err;
        unf_d = unf_q & ~bus.clear_err;
        case (op_c)
            OP_RET: begin
                if (lifo_empty) begin
                    unf_d = 1'b1;
                end else begin
                    pc_d = lifo_top;
                end
            end
            OP_CALL: begin
                if (lifo_full) begin
                    ovf_d = 1'b1;
                end else begin
                    pc_d = bus.load_value;
                end
            end
            OP_LOAD: pc_d = bus.load_value;
`ifdef PC_REL_BRANCH_EN
            OP_REL:  pc_d = pc_q + bus.rel_offset;
`endif
            OP_INC:  pc_d = pc_q + ADDR_W'(1);
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    ret_addr_lifo #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH),
        .CNT_W  (SP_W)
    ) u_lifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .data_i  (ret_addr_c),
        .top_o   (lifo_top),
        .count_o (lifo_count),
        .full_o  (lifo_full),
        .empty_o (lifo_empty)
    );

    assign bus.pc            = pc_q;
    assign bus.sp            = lifo_count;
    assign bus.stack_full    = lifo_full;
    assign bus.stack_empty   = lifo_empty;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;

endmodule

// File: tb/tb_pc_stack_counter.sv
// Randomised and directed bench for pc_stack_counter against a queue-based reference model.
module tb_pc_stack_counter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SP_W   = 3;
`ifdef PC_REL_BRANCH_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic clk;
    logic reset;

    pc_stack_counter_if #(.ADDR_W(ADDR_W), .SP_W(SP_W)) bus ();

    pc_stack_counter #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (DEPTH),
        .RESET_PC    (12'h000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passed = 0;

    // Reference model: pc as an integer, stack as a queue of return addresses.
    int unsigned pc_m = 0;
    int unsigned stk[$];
    bit          ovf_m = 1'b0;
    bit          unf_m = 1'b0;

    function automatic logic [18:0] exp_vec();
        return {12'(pc_m), 3'(stk.size()), 1'(stk.size() == DEPTH), 1'(stk.size() == 0),
                1'(ovf_m), 1'(unf_m)};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {bus.pc, bus.sp, bus.stack_full, bus.stack_empty,
                bus.overflow_err, bus.underflow_err};
    endfunction

    task automatic idle_inputs();
        bus.enable = 1'b0; bus.load = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
        bus.clear_err = 1'b0; bus.load_value = '0;
`ifdef PC_REL_BRANCH_EN
        bus.rel_branch = 1'b0; bus.rel_offset = '0;
`endif
    endtask

    task automatic model_reset();
        pc_m = 0;
        stk.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    // One clock of stimulus; the model advances by the same rules at the edge.
    task automatic cycle(input bit r, input bit c, input bit l, input bit e, input bit clr,
                         input int unsigned lv, input bit rb, input int unsigned ro);
        @(negedge clk);
        bus.ret = r; bus.call = c; bus.load = l; bus.enable = e; bus.clear_err = clr;
        bus.load_value = 12'(lv);
`ifdef PC_REL_BRANCH_EN
        bus.rel_branch = rb; bus.rel_offset = 12'(ro);
`endif
        @(posedge clk);
        if (clr) begin
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end
        if (r) begin
            if (stk.size() > 0) pc_m = stk.pop_back();
            else unf_m = 1'b1;
        end else if (c) begin
            if (stk.size() < DEPTH) begin
                stk.push_back((pc_m + 1) % 4096);
                pc_m = lv % 4096;
            end else begin
                ovf_m = 1'b1;
            end
        end else if (l) begin
            pc_m = lv % 4096;
        end else if (rb && REL_EN) begin
            pc_m = (pc_m + ro) % 4096;
        end else if (e) begin
            pc_m = (pc_m + 1) % 4096;
        end
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        checks++;
        if (dut_vec() !== 19'({12'h000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}))
            $display("FAIL reset_initial: got %h expected %h", dut_vec(),
                     19'({12'h000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        cycle(0, 0, 1, 0, 0, 12'h025, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 12'h300, 0, 0);
        checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL reset_precondition: got %h expected %h", dut_vec(), exp_vec());
        else passed++;
        // Asynchronous assertion mid-cycle with strobes active.
        @(negedge clk);
        bus.enable = 1'b1; bus.call = 1'b1; bus.load_value = 12'h123;
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== 19'({12'h000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}))
            $display("FAIL reset_async: got %h expected %h", dut_vec(),
                     19'({12'h000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL reset_hold_edge: got %h expected %h", dut_vec(), exp_vec());
        else passed++;
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (bus.pc !== 12'h003) $display("FAIL reset_release_count: got %h expected 003", bus.pc);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [11:0] exp_seq [3];
        exp_seq[0] = 12'hFFF; exp_seq[1] = 12'h000; exp_seq[2] = 12'h001;
        cycle(0, 0, 1, 0, 0, 12'hFFE, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 0, 0, 0, 0);
            checks++;
            if (bus.pc !== exp_seq[i] || dut_vec() !== exp_vec())
                $display("FAIL wrap_%0d: got pc %h vec %h expected pc %h vec %h",
                         i, bus.pc, dut_vec(), exp_seq[i], exp_vec());
            else passed++;
        end
        // A call from all-ones pushes a return address of zero.
        cycle(0, 0, 1, 0, 0, 12'hFFF, 0, 0);
        cycle(0, 1, 0, 0, 0, 12'h0A0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.pc !== 12'h000 || dut_vec() !== exp_vec())
            $display("FAIL wrap_call_ret: got %h expected %h", dut_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_call_ret();
        cycle(0, 0, 1, 0, 0, 12'h010, 0, 0);
        cycle(0, 1, 0, 0, 0, 12'h200, 0, 0);
        checks++;
        if (bus.pc !== 12'h200 || bus.sp !== 3'd1)
            $display("FAIL call_target: got pc %h sp %0d expected pc 200 sp 1", bus.pc, bus.sp);
        else passed++;
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (bus.pc !== 12'h202) $display("FAIL call_body: got %h expected 202", bus.pc);
        else passed++;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.pc !== 12'h011 || bus.sp !== 3'd0 || bus.stack_empty !== 1'b1)
            $display("FAIL call_return: got pc %h sp %0d empty %b expected pc 011 sp 0 empty 1",
                     bus.pc, bus.sp, bus.stack_empty);
        else passed++;
    endtask

    task automatic test_nested();
        logic [11:0] pc_before;
        cycle(0, 0, 1, 0, 0, 12'h100, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0, 0, $urandom_range(0, 4095), 0, 0);
            cycle(0, 0, 0, 1, 0, 0, 0, 0);
        end
        checks++;
        if (bus.stack_full !== 1'b1 || dut_vec() !== exp_vec())
            $display("FAIL nested_full: got %h expected %h", dut_vec(), exp_vec());
        else passed++;
        pc_before = bus.pc;
        cycle(0, 1, 0, 0, 0, 12'h777, 0, 0);
        checks++;
        if (bus.pc !== pc_before || bus.overflow_err !== 1'b1 || bus.sp !== 3'd4)
            $display("FAIL nested_overflow: got pc %h ovf %b sp %0d expected pc %h ovf 1 sp 4",
                     bus.pc, bus.overflow_err, bus.sp, pc_before);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL nested_ret_%0d: got %h expected %h", i, dut_vec(), exp_vec());
            else passed++;
        end
        pc_before = bus.pc;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.pc !== pc_before || bus.underflow_err !== 1'b1 || bus.overflow_err !== 1'b1)
            $display("FAIL nested_underflow: got pc %h unf %b ovf %b expected pc %h unf 1 ovf 1",
                     bus.pc, bus.underflow_err, bus.overflow_err, pc_before);
        else passed++;
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_priority();
        cycle(0, 0, 1, 0, 0, 12'h040, 0, 0);
        cycle(0, 1, 0, 0, 0, 12'h080, 0, 0);
        cycle(0, 1, 0, 0, 0, 12'h0C0, 0, 0);
        cycle(1, 1, 1, 1, 0, 12'h555, 1, 12'h010);
        checks++;
        if (bus.pc !== 12'h081 || bus.sp !== 3'd1 || dut_vec() !== exp_vec())
            $display("FAIL priority_ret_wins: got %h expected %h", dut_vec(), exp_vec());
        else passed++;
        cycle(0, 0, 1, 1, 0, 12'h3A5, 1, 12'h010);
        checks++;
        if (bus.pc !== 12'h3A5 || dut_vec() !== exp_vec())
            $display("FAIL priority_load_over_enable: got %h expected %h", dut_vec(), exp_vec());
        else passed++;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_clear_err();
        while (stk.size() > 0) cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (bus.underflow_err !== 1'b0)
            $display("FAIL clear_alone: got %b expected 0", bus.underflow_err);
        else passed++;
        cycle(1, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (bus.underflow_err !== 1'b1 || dut_vec() !== exp_vec())
            $display("FAIL clear_with_new_error: got %h expected %h", dut_vec(), exp_vec());
        else passed++;
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
    endtask

`ifdef PC_REL_BRANCH_EN
    task automatic test_rel_branch();
        cycle(0, 0, 1, 0, 0, 12'h005, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 1, 12'hFF9);
        checks++;
        if (bus.pc !== 12'hFFE) $display("FAIL rel_backward: got %h expected ffe", bus.pc);
        else passed++;
        cycle(0, 0, 0, 1, 0, 0, 1, 12'h004);
        checks++;
        if (bus.pc !== 12'h002) $display("FAIL rel_forward: got %h expected 002", bus.pc);
        else passed++;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 5) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
                  ($urandom % 2) == 0, ($urandom % 10) == 0, $urandom_range(0, 4095),
                  ($urandom % 5) == 0, $urandom_range(0, 4095));
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL random_%0d: got %h expected %h", i, dut_vec(), exp_vec());
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_wrap();
        test_call_ret();
        test_nested();
        test_priority();
        test_clear_err();
`ifdef PC_REL_BRANCH_EN
        test_rel_branch();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
